// File: rtl/sigma_tile_irq_pkg.sv
// sigma_tile_irq_pkg: shared constants and types for the tile interrupt adapter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sigma_tile_irq_pkg;

    // Register offsets, decoded on addr[7:0]
    localparam logic [7:0] ADDR_PENDING = 8'h00;   // read; write-1-to-clear
    localparam logic [7:0] ADDR_MASK    = 8'h04;   // read/write, 1 = line enabled
    localparam logic [7:0] ADDR_SET     = 8'h08;   // write-only, reads 0
    localparam logic [7:0] ADDR_STATUS  = 8'h0C;   // read {state, active code}

    typedef enum logic {
        ST_IDLE     = 1'b0,
        ST_WAIT_ACK = 1'b1
    } irq_state_e;

endpackage

// File: rtl/MemSplit32.sv
// MemSplit32: simple split request/response register bus, 32-bit address and data.
// Latency: defined by the slave; ack is same-cycle, read response follows separately.
// Backpressure: none; the slave acknowledges every request.
interface MemSplit32;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        ack;
    logic        resp;
    logic [31:0] rdata;

    modport Slave  (input  req, we, addr, wdata, output ack, resp, rdata);
    modport Master (output req, we, addr, wdata, input  ack, resp, rdata);
endinterface

// File: rtl/irq_prio_enc.sv
// irq_prio_enc: lowest-index-first priority encoder.
// Latency: combinational.
// Backpressure: n/a.
// Ports: vec_i - request vector; vld_o - any bit set; idx_o - index of the lowest set bit (0 when none).
module irq_prio_enc #(
    parameter int IRQ_NUM_POW = 4
) (
    input  logic [2**IRQ_NUM_POW-1:0] vec_i,
    output logic                      vld_o,
    output logic [IRQ_NUM_POW-1:0]    idx_o
);
    localparam int N = 2**IRQ_NUM_POW;

    always_comb begin
        vld_o = |vec_i;
        idx_o = '0;
        // Scan downward so the lowest set index is the last one written.
        for (int i = N - 1; i >= 0; i--) begin
            if (vec_i[i]) begin
                idx_o = IRQ_NUM_POW'(i);
            end
        end
    end
endmodule

// File: rtl/irq_adapter.sv
// irq_adapter: collects edge, timer and software interrupts into PENDING and presents one request at a time to the core.
// Latency: line edge sampled -> pending next cycle -> core_irq_req_o the cycle after; host reads respond one cycle after req.
// Backpressure: a request is held stable until core_irq_ack_i; new events keep accumulating in PENDING meanwhile.
// Ports: clk_i/rst_i clock and async active-high reset; host register bus (PENDING/MASK/SET/STATUS);
//        irq_bi level lines; irq_timer_i timer pulse; sgi_req_i/sgi_code_bi software interrupt;
//        core_irq_req_o/core_irq_code_bo/core_irq_ack_i request handshake to the core.
module irq_adapter #(
    parameter int IRQ_NUM_POW = 4,
    parameter int TIMER_LINE  = 0
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    MemSplit32.Slave                    host,
    input  logic [2**IRQ_NUM_POW-1:0]   irq_bi,
    input  logic                        irq_timer_i,
    input  logic                        sgi_req_i,
    input  logic [IRQ_NUM_POW-1:0]      sgi_code_bi,
    output logic                        core_irq_req_o,
    output logic [IRQ_NUM_POW-1:0]      core_irq_code_bo,
    input  logic                        core_irq_ack_i
);
    import sigma_tile_irq_pkg::*;

    localparam int N = 2**IRQ_NUM_POW;

    logic [N-1:0]           pending_q, pending_d;
    logic [N-1:0]           mask_q, mask_d;
    logic [N-1:0]           irq_prev_q;
    irq_state_e             state_q, state_d;
    logic                   req_q, req_d;
    logic [IRQ_NUM_POW-1:0] code_q, code_d;
    logic                   resp_q;
    logic [31:0]            rdata_q, rdata_d;

    logic [7:0]             reg_addr;
    logic                   wr_en;
    logic                   rd_en;
    logic                   ack_take;
    logic [N-1:0]           set_vec;
    logic [N-1:0]           clr_vec;
    logic [N-1:0]           active_vec;
    logic                   enc_vld;
    logic [IRQ_NUM_POW-1:0] enc_idx;
    logic                   unused_host_bits;

    assign reg_addr = host.addr[7:0];
    assign wr_en    = host.req &  host.we;
    assign rd_en    = host.req & ~host.we;
    // Acks arriving while idle are ignored.
    assign ack_take = (state_q == ST_WAIT_ACK) & core_irq_ack_i;

    // Only addr[7:0] is decoded and only the low N wdata bits map to lines.
    assign unused_host_bits = ^{host.addr[31:8], host.wdata};

    // ------------------------------------------------------------------
    // Pending / mask update. Set sources are OR-ed after the clear so a
    // coinciding set always wins over an ack or write-1-to-clear.
    // ------------------------------------------------------------------
    always_comb begin
        set_vec = irq_bi & ~irq_prev_q;
        if (irq_timer_i) begin
            set_vec[TIMER_LINE] = 1'b1;
        end
        if (sgi_req_i) begin
            set_vec[sgi_code_bi] = 1'b1;
        end
        if (wr_en && (reg_addr == ADDR_SET)) begin
            set_vec = set_vec | host.wdata[N-1:0];
        end

        clr_vec = '0;
        if (wr_en && (reg_addr == ADDR_PENDING)) begin
            clr_vec = host.wdata[N-1:0];
        end
        // Clears whatever is at the latched code, even if it was already
        // cleared or masked while the request was outstanding.
        if (ack_take) begin
            clr_vec[code_q] = 1'b1;
        end
    end

    assign pending_d  = (pending_q & ~clr_vec) | set_vec;
    assign mask_d     = (wr_en && (reg_addr == ADDR_MASK)) ? host.wdata[N-1:0] : mask_q;
    assign active_vec = pending_q & mask_q;

    irq_prio_enc #(
        .IRQ_NUM_POW (IRQ_NUM_POW)
    ) u_prio_enc (
        .vec_i (active_vec),
        .vld_o (enc_vld),
        .idx_o (enc_idx)
    );

    // ------------------------------------------------------------------
    // Request FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (enc_vld) begin
                    state_d = ST_WAIT_ACK;
                end
            end
            ST_WAIT_ACK: begin
                if (core_irq_ack_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Request FSM: outputs. The code is latched on entry to WAIT_ACK and
    // kept afterwards so STATUS shows the last serviced line.
    // ------------------------------------------------------------------
    always_comb begin
        req_d  = req_q;
        code_d = code_q;
        case (state_q)
            ST_IDLE: begin
                req_d = 1'b0;
                if (enc_vld) begin
                    req_d  = 1'b1;
                    code_d = enc_idx;
                end
            end
            ST_WAIT_ACK: begin
                if (core_irq_ack_i) begin
                    req_d = 1'b0;
                end
            end
            default: req_d = 1'b0;
        endcase
    end

    // ------------------------------------------------------------------
    // Host read mux (sampled into rdata_q, returned one cycle later)
    // ------------------------------------------------------------------
    always_comb begin
        rdata_d = '0;
        case (reg_addr)
            ADDR_PENDING: rdata_d = 32'(pending_q);
            ADDR_MASK:    rdata_d = 32'(mask_q);
            ADDR_STATUS:  rdata_d = 32'({state_q == ST_WAIT_ACK, code_q});
            default:      rdata_d = '0;
        endcase
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pending_q  <= '0;
            mask_q     <= '0;
            irq_prev_q <= '0;
            req_q      <= 1'b0;
            code_q     <= '0;
            resp_q     <= 1'b0;
            rdata_q    <= '0;
        end else begin
            pending_q  <= pending_d;
            mask_q     <= mask_d;
            irq_prev_q <= irq_bi;
            req_q      <= req_d;
            code_q     <= code_d;
            resp_q     <= rd_en;
            if (rd_en) begin
                rdata_q <= rdata_d;
            end
        end
    end

    assign host.ack         = host.req;
    assign host.resp        = resp_q;
    assign host.rdata       = rdata_q;
    assign core_irq_req_o   = req_q;
    assign core_irq_code_bo = code_q;

endmodule

// File: tb/tb_irq_adapter.sv
module tb_irq_adapter;
    import sigma_tile_irq_pkg::*;

    localparam int POW = 4;
    localparam int N   = 16;
    localparam int TL  = 0;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    irq_bi = '0;
    logic            irq_timer = 1'b0;
    logic            sgi_req = 1'b0;
    logic [POW-1:0]  sgi_code = '0;
    logic            ack = 1'b0;
    logic            req_o;
    logic [POW-1:0]  code_o;

    MemSplit32 host_if();

    irq_adapter #(
        .IRQ_NUM_POW (POW),
        .TIMER_LINE  (TL)
    ) dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .host             (host_if),
        .irq_bi           (irq_bi),
        .irq_timer_i      (irq_timer),
        .sgi_req_i        (sgi_req),
        .sgi_code_bi      (sgi_code),
        .core_irq_req_o   (req_o),
        .core_irq_code_bo (code_o),
        .core_irq_ack_i   (ack)
    );

    always #5 clk = ~clk;

    // Expected observable events
    typedef struct { logic lvl; logic [POW-1:0] code; int cyc; } irq_ev_t;
    typedef struct { logic [31:0] data; int cyc; } rd_ev_t;
    irq_ev_t ev_q[$];
    rd_ev_t  rd_q[$];

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    // Reference model: pending/mask as plain bit sets, "busy" + "code" for the core handshake
    logic [N-1:0]   m_pend = '0;
    logic [N-1:0]   m_mask = '0;
    logic [N-1:0]   m_prev = '0;
    bit             m_busy = 1'b0;
    logic [POW-1:0] m_code = '0;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_pend = '0; m_mask = '0; m_prev = '0; m_busy = 1'b0; m_code = '0;
    endtask

    function automatic logic [POW-1:0] lowest(logic [N-1:0] v);
        logic [POW-1:0] r = '0;
        for (int i = N - 1; i >= 0; i--) if (v[i]) r = POW'(i);
        return r;
    endfunction

    // Called right after each active edge with the inputs the DUT just sampled.
    task automatic model_tick();
        logic [N-1:0] setv;
        logic [N-1:0] clrv;
        logic [N-1:0] nmask;
        logic [31:0]  rd;
        logic [7:0]   a;
        irq_ev_t      ev;
        rd_ev_t       re;
        cyc++;
        a     = host_if.addr[7:0];
        setv  = irq_bi & ~m_prev;
        clrv  = '0;
        nmask = m_mask;
        if (irq_timer) setv[TL] = 1'b1;
        if (sgi_req) setv[sgi_code] = 1'b1;
        if (host_if.req && host_if.we) begin
            if (a == 8'h00) clrv = host_if.wdata[N-1:0];
            if (a == 8'h04) nmask = host_if.wdata[N-1:0];
            if (a == 8'h08) setv = setv | host_if.wdata[N-1:0];
        end
        if (host_if.req && !host_if.we) begin
            case (a)
                8'h00:   rd = 32'(m_pend);
                8'h04:   rd = 32'(m_mask);
                8'h0C:   rd = 32'({m_busy, m_code});
                default: rd = 32'h0;
            endcase
            re.data = rd; re.cyc = cyc;
            rd_q.push_back(re);
        end
        if (m_busy) begin
            if (ack) begin
                clrv[m_code] = 1'b1;
                m_busy = 1'b0;
                ev.lvl = 1'b0; ev.code = m_code; ev.cyc = cyc;
                ev_q.push_back(ev);
            end
        end else if ((m_pend & m_mask) != '0) begin
            m_busy = 1'b1;
            m_code = lowest(m_pend & m_mask);
            ev.lvl = 1'b1; ev.code = m_code; ev.cyc = cyc;
            ev_q.push_back(ev);
        end
        m_pend = (m_pend & ~clrv) | setv;
        m_mask = nmask;
        m_prev = irq_bi;
    endtask

    task automatic step();
        #1;
        if (host_if.req) chk("host_ack", 32'(host_if.ack), 32'h1);
        @(posedge clk);
        model_tick();
        #1;
        host_if.req = 1'b0; host_if.we = 1'b0;
        irq_timer = 1'b0; sgi_req = 1'b0; ack = 1'b0;
    endtask

    task automatic host_wr(logic [7:0] a, logic [31:0] d);
        host_if.req = 1'b1; host_if.we = 1'b1; host_if.addr = {24'h0, a}; host_if.wdata = d;
        step();
    endtask

    task automatic host_rd(logic [7:0] a);
        host_if.req = 1'b1; host_if.we = 1'b0; host_if.addr = {24'h0, a}; host_if.wdata = 32'h0;
        step();
    endtask

    task automatic drain();
        bit done = 1'b0;
        for (int i = 0; i < 200 && !done; i++) begin
            ack = m_busy;
            step();
            done = !m_busy && ((m_pend & m_mask) == '0);
        end
        chk("drain_done", 32'(done), 32'h1);
    endtask

    // Monitor: pops expectations whenever the DUT shows a read response or a request edge.
    logic           mon_prev_req = 1'b0;
    logic [POW-1:0] mon_code = '0;
    irq_ev_t        mon_ev;
    rd_ev_t         mon_rd;

    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                mon_prev_req = 1'b0;
            end else begin
                while (ev_q.size() > 0 && ev_q[0].cyc < cyc) begin
                    mon_ev = ev_q.pop_front();
                    chk("irq_missing_edge", 32'(req_o), 32'(mon_ev.lvl));
                end
                while (rd_q.size() > 0 && rd_q[0].cyc < cyc) begin
                    mon_rd = rd_q.pop_front();
                    chk("rd_missing_resp", 32'(host_if.resp), 32'h1);
                end
                if (host_if.resp) begin
                    if (rd_q.size() == 0) begin
                        chk("rd_unexpected_resp", 32'(host_if.resp), 32'h0);
                    end else begin
                        mon_rd = rd_q.pop_front();
                        chk("rd_data", host_if.rdata, mon_rd.data);
                    end
                end
                if (req_o !== mon_prev_req) begin
                    if (ev_q.size() == 0) begin
                        chk("irq_unexpected_edge", 32'(req_o), 32'(mon_prev_req));
                    end else begin
                        mon_ev = ev_q.pop_front();
                        chk("irq_level", 32'(req_o), 32'(mon_ev.lvl));
                        if (mon_ev.lvl) chk("irq_code", 32'(code_o), 32'(mon_ev.code));
                    end
                end else if (req_o && (code_o !== mon_code)) begin
                    chk("irq_code_stable", 32'(code_o), 32'(mon_code));
                end
                mon_prev_req = req_o;
                mon_code = code_o;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] tmp;
        logic [7:0]  a;
        host_if.req = 1'b0; host_if.we = 1'b0; host_if.addr = '0; host_if.wdata = '0;

        // Reset state
        repeat (3) @(posedge clk);
        #3 rst = 1'b0;
        chk("rst_req", 32'(req_o), 32'h0);
        chk("rst_code", 32'(code_o), 32'h0);
        chk("rst_resp", 32'(host_if.resp), 32'h0);
        chk("rst_rdata", host_if.rdata, 32'h0);
        host_rd(ADDR_MASK);
        chk("rst_mask_rd", host_if.rdata, 32'h0);

        // Edge latency on line 5
        host_wr(ADDR_MASK, 32'hFFFF);
        repeat (3) step();
        irq_bi[5] = 1'b1;
        step();
        chk("edge_req_early", 32'(req_o), 32'h0);
        step();
        chk("edge_req", 32'(req_o), 32'h1);
        chk("edge_code", 32'(code_o), 32'd5);
        step();
        ack = 1'b1;
        step();
        chk("edge_ack_drop", 32'(req_o), 32'h0);
        host_rd(ADDR_PENDING);
        chk("edge_pend_clear", host_if.rdata, 32'h0);

        // Priority: bits 3 and 9 together
        host_wr(ADDR_SET, 32'h0208);
        chk("prio_req_early", 32'(req_o), 32'h0);
        step();
        chk("prio_first_code", 32'(code_o), 32'd3);
        host_rd(ADDR_STATUS);
        chk("prio_status", host_if.rdata, 32'h13);
        ack = 1'b1;
        step();
        chk("prio_idle_gap", 32'(req_o), 32'h0);
        step();
        chk("prio_second_req", 32'(req_o), 32'h1);
        chk("prio_second_code", 32'(code_o), 32'd9);
        ack = 1'b1;
        step();

        // Masking with SGI line 7
        host_wr(ADDR_MASK, 32'h0);
        sgi_req = 1'b1; sgi_code = 4'd7;
        step();
        repeat (3) step();
        chk("mask_no_req", 32'(req_o), 32'h0);
        host_rd(ADDR_PENDING);
        chk("mask_pend", host_if.rdata, 32'h0080);
        host_wr(ADDR_MASK, 32'h0080);
        chk("mask_req_early", 32'(req_o), 32'h0);
        step();
        chk("mask_req", 32'(req_o), 32'h1);
        chk("mask_code", 32'(code_o), 32'd7);
        ack = 1'b1;
        step();

        // Set wins: timer pulse coincides with ack of line 0
        host_wr(ADDR_MASK, 32'hFFFF);
        host_wr(ADDR_SET, 32'h0001);
        step();
        chk("setwin_req", 32'(req_o), 32'h1);
        chk("setwin_code", 32'(code_o), 32'd0);
        ack = 1'b1; irq_timer = 1'b1;
        step();
        chk("setwin_drop", 32'(req_o), 32'h0);
        step();
        chk("setwin_rereq", 32'(req_o), 32'h1);
        chk("setwin_recode", 32'(code_o), 32'd0);
        ack = 1'b1;
        step();

        // Host SET / W1C / unmapped addresses
        host_wr(ADDR_MASK, 32'h0);
        host_wr(ADDR_SET, 32'h0011);
        host_rd(ADDR_PENDING);
        chk("host_resp", 32'(host_if.resp), 32'h1);
        chk("host_set_rd", host_if.rdata, 32'h0011);
        host_wr(ADDR_PENDING, 32'h0001);
        host_rd(ADDR_PENDING);
        chk("host_w1c_rd", host_if.rdata, 32'h0010);
        host_rd(ADDR_SET);
        chk("host_set_reads0", host_if.rdata, 32'h0);
        host_wr(8'h10, 32'hFFFF);
        host_rd(8'h10);
        chk("host_unmapped", host_if.rdata, 32'h0);
        host_wr(ADDR_PENDING, 32'hFFFF);

        // Randomised traffic against the model
        for (int i = 0; i < 3000; i++) begin
            irq_bi    = irq_bi ^ N'($urandom & $urandom & $urandom);
            irq_timer = ($urandom_range(0, 15) == 0);
            sgi_req   = ($urandom_range(0, 15) == 0);
            sgi_code  = POW'($urandom);
            ack       = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 3) == 0) begin
                case ($urandom_range(0, 5))
                    0:       a = 8'h00;
                    1:       a = 8'h04;
                    2:       a = 8'h08;
                    3:       a = 8'h0C;
                    4:       a = 8'h10;
                    default: a = 8'h1C;
                endcase
                tmp = $urandom;
                host_if.req   = 1'b1;
                host_if.we    = 1'($urandom_range(0, 1));
                host_if.addr  = {tmp[31:8], a};
                host_if.wdata = $urandom & $urandom;
            end
            step();
        end
        drain();

        // Reset while a request is outstanding
        host_wr(ADDR_PENDING, 32'hFFFF);
        host_wr(ADDR_MASK, 32'hFFFF);
        host_wr(ADDR_SET, 32'h0004);
        step();
        chk("rstmid_req", 32'(req_o), 32'h1);
        chk("rstmid_code", 32'(code_o), 32'd2);
        #1 rst = 1'b1;
        #1 chk("rstmid_drop", 32'(req_o), 32'h0);
        ev_q.delete();
        rd_q.delete();
        model_reset();
        irq_bi = '0;
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        host_rd(ADDR_PENDING);
        chk("rstmid_pend", host_if.rdata, 32'h0);
        repeat (3) step();
        chk("rstmid_no_req", 32'(req_o), 32'h0);

        chk("ev_q_empty", 32'(ev_q.size()), 32'h0);
        chk("rd_q_empty", 32'(rd_q.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
